voice_playback_feeder: RTL and testbench

- Downstream consumer of the SDRAM voice FIFO.
- Requests one wave (WAVE_SIZE words) at a time from the FIFO's read side and captures the returned words while the FIFO's data-valid strobe is high.
- Buffers the words in a local on-chip FIFO.
- Releases one sample per sample-rate tick to the DAC/audio output stage, inserting silence and flagging underrun when the buffer is empty.

---
 rtl/voice_playback_feeder.sv | 151 +++++++++++++++
 tb/tb_voice_playback_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_playback_feeder.sv
// Pulls WAVE_SIZE-word waves from the SDRAM voice FIFO into a local buffer and plays one sample per divider tick.
// Sample appears 1 clock after the tick; empty buffer gives silence + o_underrun, full buffer drops words with o_overflow.
module voice_playback_feeder #(
   parameter int WAVE_SIZE   = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int BUF_AW      = 6,
   parameter int SAMPLE_DIV  = 6250,
   parameter int DIV_WIDTH   = 13,
   parameter int REQ_TIMEOUT = 255,
   parameter int GAP_TIMEOUT = 31
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   input  logic                  i_rd_ef,
   input  logic                  i_rd_done,
   output logic [DATA_WIDTH-1:0] o_sample,
   output logic                  o_sample_valid,
   output logic                  o_underrun,
   output logic                  o_overflow,
   output logic [BUF_AW:0]       o_level
);

   localparam int DEPTH   = 1 << BUF_AW;
   localparam int TMR_MAX = (REQ_TIMEOUT > GAP_TIMEOUT) ? REQ_TIMEOUT : GAP_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [BUF_AW:0]       FULL_LVL = (BUF_AW+1)'(DEPTH);
   localparam logic [BUF_AW:0]       REQ_LVL  = (BUF_AW+1)'(DEPTH - WAVE_SIZE);
   localparam logic [DIV_WIDTH-1:0]  DIV_LAST = DIV_WIDTH'(SAMPLE_DIV - 1);
   localparam logic [TMR_W-1:0]      REQ_TMO  = TMR_W'(REQ_TIMEOUT);
   localparam logic [TMR_W-1:0]      GAP_TMO  = TMR_W'(GAP_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RECV
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [BUF_AW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [DIV_WIDTH-1:0]  div;
   logic [TMR_W-1:0]      tmr;
   logic                  tick, full, empty, push, pop;
   logic                  rd_req, tmr_clr;

   assign full  = (o_level == FULL_LVL);
   assign empty = (o_level == '0);
   assign push  = i_rd_ef && !full;
   assign tick  = (div == DIV_LAST) && i_en;
   assign pop   = tick && !empty;

   assign wr_nxt = wr_ptr + {{BUF_AW{1'b0}}, push};
   assign rd_nxt = rd_ptr + {{BUF_AW{1'b0}}, pop};

   // Capture runs regardless of FSM state so late words from a closed request are still kept.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr[BUF_AW-1:0]] <= i_rd_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
      end else begin
         wr_ptr  <= wr_nxt;
         rd_ptr  <= rd_nxt;
         o_level <= wr_nxt - rd_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         div <= '0;
      end else if (!i_en || tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sample       <= '0;
         o_sample_valid <= 1'b0;
         o_underrun     <= 1'b0;
         o_overflow     <= 1'b0;
      end else begin
         o_sample_valid <= tick;
         o_underrun     <= tick && empty;
         o_overflow     <= i_rd_ef && full;
         if (pop) begin
            o_sample <= mem[rd_ptr[BUF_AW-1:0]];
         end else if (tick) begin
            o_sample <= '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;
         o_rd  <= 1'b0;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         o_rd  <= rd_req;
         tmr   <= tmr_clr ? '0 : tmr + 1'b1;
      end
   end

   // A valid word wins over a dropped enable so a wave already flowing is finished.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (i_en && (o_level <= REQ_LVL)) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (i_rd_ef) begin
               state_nxt = S_RECV;
            end else if (!i_en || (tmr == REQ_TMO)) begin
               state_nxt = S_IDLE;
            end
         end
         S_RECV: begin
            if (i_rd_done) begin
               state_nxt = S_IDLE;
            end else if (!i_rd_ef && (tmr == GAP_TMO)) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_req  = (state_nxt == S_REQ) || (state_nxt == S_RECV);
      tmr_clr = (state == S_IDLE) || (state_nxt != state) || i_rd_ef;
   end

endmodule

// File: tb/tb_voice_playback_feeder.sv
// Directed bench: SDRAM FIFO side driven by hand, output samples checked by a scoreboard-fed monitor.
// SAMPLE_DIV is shortened to 4 so drains are quick; timeouts keep their real values.
module tb_voice_playback_feeder;

   localparam int DW     = 16;
   localparam int AW     = 6;
   localparam int SDIV   = 4;
   localparam int REQ_TO = 255;
   localparam int GAP_TO = 31;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          en    = 1'b0;
   logic          ef    = 1'b0;
   logic          done  = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          rd, sval, urun, ovf;
   logic [DW-1:0] sample;
   logic [AW:0]   level;

   always #5 clk = ~clk;

   voice_playback_feeder #(
      .WAVE_SIZE(16), .DATA_WIDTH(DW), .BUF_AW(AW), .SAMPLE_DIV(SDIV),
      .DIV_WIDTH(3), .REQ_TIMEOUT(REQ_TO), .GAP_TIMEOUT(GAP_TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .o_rd(rd),
      .i_rd_data(rdata), .i_rd_ef(ef), .i_rd_done(done),
      .o_sample(sample), .o_sample_valid(sval), .o_underrun(urun),
      .o_overflow(ovf), .o_level(level)
   );

   typedef struct packed {
      logic [DW-1:0] dat;
      logic          urun;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0, last_v = -1, brk_cyc = 0;
   int   ovf_cnt = 0, rd_rises = 0;
   logic rd_d = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Word is written at the posedge; it is queued only after that edge so an
   // underrun from an earlier tick is never matched against it.
   task automatic send_word(input logic [DW-1:0] d, input bit queue_it);
      ef = 1'b1;
      rdata = d;
      @(posedge clk);
      if (queue_it) exp_q.push_back('{dat: d, urun: 1'b0});
      @(negedge clk);
      ef = 1'b0;
   endtask

   task automatic wait_rd(input logic v, input int max, input string name);
      int n = 0;
      while (rd !== v && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, rd, v);
   endtask

   task automatic wait_level(input logic [AW:0] v, input int max, input string name);
      int n = 0;
      while (level !== v && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, level, v);
   endtask

   // Any divider reset (enable low or reset) breaks the tick spacing chain.
   initial forever begin
      @(posedge clk);
      if (rst || !en) brk_cyc = cyc;
   end

   // With nothing queued the buffer must be empty, so silence with underrun is expected.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (rd && !rd_d) rd_rises++;
         if (ovf) ovf_cnt++;
         if (sval) begin
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else mon_e = '{dat: 16'h0000, urun: 1'b1};
            check("sample", sample, mon_e.dat);
            check("underrun", urun, mon_e.urun);
            if (last_v >= 0 && brk_cyc < last_v) check("tick_spacing", cyc - last_v, SDIV);
            last_v = cyc;
         end
      end
      rd_d = rd;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, lo, lvl0, ovf0, rises0;

      repeat (3) @(negedge clk);
      check("rst_rd", rd, 0);
      check("rst_sval", sval, 0);
      check("rst_sample", sample, 0);
      check("rst_urun", urun, 0);
      check("rst_ovf", ovf, 0);
      check("rst_level", level, 0);
      rst = 1'b0;
      tick_n(1);

      // One full wave; enable drops with the first word so nothing plays yet.
      rises0 = rd_rises;
      en = 1'b1;
      wait_rd(1'b1, 4, "t1_rd_assert");
      en = 1'b0;
      for (int i = 0; i < 16; i++) send_word(16'h0100 + 16'(i), 1'b1);
      check("t1_level", level, 16);
      check("t1_rd_before_done", rd, 1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("t1_rd_after_done", rd, 0);
      tick_n(3);
      check("t1_rd_stays_low", rd, 0);
      check("t1_single_request", rd_rises - rises0, 1);

      // Play the 16 words, then exactly one queued silence for the 17th tick.
      exp_q.push_back('{dat: 16'h0000, urun: 1'b1});
      en = 1'b1;
      wait_level('0, 16 * SDIV + 10, "t2_drained");
      lo = 0;
      while (exp_q.size() != 0 && lo < 3 * SDIV) begin
         @(negedge clk);
         lo++;
      end
      check("t2_queue_empty", exp_q.size(), 0);

      // FIFO never answers: request lives REQ_TIMEOUT+1 clocks, one idle clock, then retries.
      wait_rd(1'b0, 300, "t3_first_drop");
      lo = 0;
      while (rd === 1'b0 && lo < 10) begin @(negedge clk); lo++; end
      check("t3_low_clocks", lo, 1);
      hi = 0;
      while (rd === 1'b1 && hi < 400) begin @(negedge clk); hi++; end
      check("t3_high_clocks", hi, REQ_TO + 1);
      lo = 0;
      while (rd === 1'b0 && lo < 10) begin @(negedge clk); lo++; end
      check("t3_low_clocks_2", lo, 1);
      check("t3_level", level, 0);

      // Partial wave: 8 words, then the gap timer closes RECV after GAP_TIMEOUT+1 idle clocks.
      en = 1'b0;
      for (int i = 0; i < 8; i++) send_word(16'h0400 + 16'(i), 1'b1);
      hi = 0;
      while (rd === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
      check("t4_gap_close", hi, GAP_TO + 1);
      check("t4_level", level, 8);
      en = 1'b1;
      wait_rd(1'b1, 3, "t4_next_request");

      // Request threshold: 49 words blocks, the first pop to 48 releases it.
      wait_level('0, 8 * SDIV + 20, "t5_pre_drain");
      tick_n(2);
      en = 1'b0;
      tick_n(2);
      check("t5_rd_idle", rd, 0);
      for (int i = 0; i < 49; i++) send_word(16'h0500 + 16'(i), 1'b1);
      check("t5_level_49", level, 49);
      en = 1'b1;
      lo = 0;
      while (level !== 7'd48 && lo < 10) begin
         check("t5_no_req_at_49", rd, 0);
         @(negedge clk);
         lo++;
      end
      check("t5_level_48", level, 48);
      check("t5_rd_low_at_48", rd, 0);
      @(negedge clk);
      check("t5_rd_req_at_48", rd, 1);

      lo = 0;
      while (!sval && lo < 8) begin @(negedge clk); lo++; end
      check("t5_tick_found", sval, 1);
      tick_n(SDIV - 1);
      lvl0 = int'(level);
      ef = 1'b1;
      rdata = 16'h05AA;
      @(posedge clk);
      exp_q.push_back('{dat: 16'h05AA, urun: 1'b0});
      @(negedge clk);
      ef = 1'b0;
      check("t5_push_pop_level", level, lvl0);
      check("t5_push_pop_tick", sval, 1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      wait_level('0, 60 * SDIV, "t5_drained");
      tick_n(1);
      en = 1'b0;
      tick_n(3);
      check("t5_sb_empty", exp_q.size(), 0);

      // Overflow: 65 words with nothing draining.
      ovf0 = ovf_cnt;
      for (int i = 0; i < 65; i++) send_word(16'h0600 + 16'(i), i < 64);
      check("t6_level_full", level, 64);
      tick_n(1);
      check("t6_ovf_pulses", ovf_cnt - ovf0, 1);
      check("t6_no_req_full", rd, 0);

      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      check("t6_rst_clears_full", level, 0);
      rst = 1'b0;

      // Reset in the middle of a wave acts without a clock edge.
      en = 1'b1;
      wait_rd(1'b1, 4, "t6_req");
      en = 1'b0;
      send_word(16'h0700, 1'b1);
      send_word(16'h0701, 1'b1);
      check("t6_recv_level", level, 2);
      check("t6_recv_rd", rd, 1);
      #2;
      rst = 1'b1;
      ef = 1'b1;
      rdata = 16'h0702;
      #1;
      check("t6_async_rd", rd, 0);
      check("t6_async_level", level, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_ef_in_reset_ignored", level, 0);
      ef = 1'b0;
      rst = 1'b0;
      tick_n(3);
      check("t6_post_rst_level", level, 0);
      check("t6_post_rst_rd", rd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
